// File: rtl/hack_pkg.sv
// Shared definitions for the CPU16 boot-loader slice.
//   HACK_ADDR_W / HACK_DATA_W : instruction ROM geometry (matches CPU16 pc / word width)
//   ld_state_e                : boot-loader FSM states
//   ld_takes_byte / ld_is_busy: state classification helpers
package hack_pkg;

  localparam int unsigned HACK_ADDR_W = 15;
  localparam int unsigned HACK_DATA_W = 16;

  typedef enum logic [3:0] {
    LD_IDLE,
    LD_LEN_HI,
    LD_LEN_LO,
    LD_DATA_HI,
    LD_DATA_LO,
    LD_WRITE,
    LD_CHECK,
    LD_DONE,
    LD_ERROR
  } ld_state_e;

  // States in which the loader is waiting for a stream byte.
  function automatic logic ld_takes_byte(input ld_state_e s);
    return (s == LD_LEN_HI) || (s == LD_LEN_LO) || (s == LD_DATA_HI) ||
           (s == LD_DATA_LO) || (s == LD_CHECK);
  endfunction

  // A load is in progress from the first length byte through the checksum.
  function automatic logic ld_is_busy(input ld_state_e s);
    return ld_takes_byte(s) || (s == LD_WRITE);
  endfunction

endpackage

// File: rtl/hack_timeout_ctr.sv
// Idle-cycle watchdog for the boot loader.
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : restart the count (byte accepted or new waiting state entered)
//   enable_i   : loader is waiting for a byte this cycle
//   expired_o  : this waiting cycle is the LIMIT-th one; LIMIT = 0 never expires
module hack_timeout_ctr #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Flag on the cycle whose edge would complete LIMIT waiting cycles, so the
  // loader lands in ERROR exactly LIMIT cycles after it started waiting.
  assign expired_o = (LIMIT != 0) && enable_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hack_boot_loader.sv
// CPU16 boot loader: receives a framed program image from a byte stream, writes
// it into the instruction ROM and releases the CPU only after the XOR checksum
// matches.
//   Frame: LEN_HI LEN_LO, N x (hi lo), CSUM (XOR of all preceding bytes)
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin a load (ignored while busy)
//   rx_data/rx_valid    : stream byte in, transferred when rx_valid & rx_ready
//   rx_ready            : loader is waiting for a byte
//   rom_addr/wdata/we   : instruction ROM write port, one-cycle strobe per word
//   cpu_rst             : CPU16 reset, low only once the image is verified
//   busy/done/error     : load status
module hack_boot_loader
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W  = HACK_ADDR_W,
  parameter int unsigned DATA_W  = HACK_DATA_W,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              rom_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  ld_state_e         state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rom_wdata_q, rom_wdata_d;
  logic              rom_we_q, rom_we_d;
  logic              rx_ready_q, rx_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic        xfer;
  logic [15:0] len_w;
  logic        tmo_clear, tmo_enable, tmo_expired;

  assign xfer  = rx_valid && rx_ready_q;
  // hi_q holds LEN_HI while in LEN_LO, so the full count is available on the LEN_LO byte.
  assign len_w = {hi_q, rx_data};

  assign tmo_enable = ld_takes_byte(state_q) && !xfer;
  assign tmo_clear  = xfer || (state_d != state_q);

  hack_timeout_ctr #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmo_clear),
    .enable_i (tmo_enable),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    rem_d       = rem_q;
    csum_d      = xfer ? (csum_q ^ rx_data) : csum_q;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;

    unique case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) begin
          state_d    = LD_LEN_HI;
          rom_addr_d = '0;
          csum_d     = '0;
        end
      end
      LD_LEN_HI: begin
        if (xfer) begin
          hi_d    = rx_data;
          state_d = LD_LEN_LO;
        end
      end
      LD_LEN_LO: begin
        if (xfer) begin
          rem_d = len_w;
          if (len_w == 16'd0) begin
            state_d = LD_CHECK;
          end else if (32'(len_w) > MAX_WORDS) begin
            state_d = LD_ERROR;
          end else begin
            state_d = LD_DATA_HI;
          end
        end
      end
      LD_DATA_HI: begin
        if (xfer) begin
          hi_d    = rx_data;
          state_d = LD_DATA_LO;
        end
      end
      LD_DATA_LO: begin
        if (xfer) begin
          rom_wdata_d = DATA_W'({hi_q, rx_data});
          state_d     = LD_WRITE;
        end
      end
      LD_WRITE: begin
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        rem_d      = rem_q - 16'd1;
        state_d    = (rem_q == 16'd1) ? LD_CHECK : LD_DATA_HI;
      end
      LD_CHECK: begin
        if (xfer) begin
          state_d = (rx_data == csum_q) ? LD_DONE : LD_ERROR;
        end
      end
      default: state_d = LD_IDLE;
    endcase

    // Expiry is only raised on a waiting cycle without a transfer.
    if (tmo_expired) begin
      state_d = LD_ERROR;
    end

    // Outputs are registered from the next state so they line up with state_q.
    rom_we_d   = (state_d == LD_WRITE);
    rx_ready_d = ld_takes_byte(state_d);
    busy_d     = ld_is_busy(state_d);
    done_d     = (state_d == LD_DONE);
    error_d    = (state_d == LD_ERROR);
    cpu_rst_d  = (state_d != LD_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LD_IDLE;
      hi_q        <= '0;
      rem_q       <= '0;
      csum_q      <= '0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      rom_we_q    <= 1'b0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      rem_q       <= rem_d;
      csum_q      <= csum_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      rom_we_q    <= rom_we_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_rst_q   <= cpu_rst_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign rom_we    = rom_we_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Self-checking bench for hack_boot_loader: directed frames from the datasheet
// plus random frames with random stream gaps, checked against a frame-level
// model of the expected ROM writes and final status.
module tb_hack_boot_loader;

  localparam int unsigned AW  = 15;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 16;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_wdata;
  logic          rom_we;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;

  logic [AW+DW-1:0] cap[$];

  hack_boot_loader #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rom_addr (rom_addr),
    .rom_wdata(rom_wdata),
    .rom_we   (rom_we),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Record every ROM write; the stream must be stalled while a word is written.
  always @(negedge clk) begin
    if (!rst && rom_we) begin
      cap.push_back({rom_addr, rom_wdata});
      check("rdy_in_write", 32'(rx_ready), 32'd0);
    end
  end

  function automatic bq_t make_frame(input int n, input bit corrupt);
    bq_t f;
    logic [7:0] cs;
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) f.push_back(8'($urandom));
    cs = 8'h00;
    foreach (f[i]) cs ^= f[i];
    if (corrupt) cs ^= 8'($urandom_range(1, 255));
    f.push_back(cs);
    return f;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Entered and left at a negedge; returns half a cycle after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gmax, input bit with_start);
    int n;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, gmax)) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    start    = with_start;
    n = 0;
    while (!rx_ready && n < 64) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (n >= 64) check("accept_wait", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_frame(input bq_t f, input int gmax, input bit poke);
    int n, consumed, w;
    bit too_big, ok;
    logic [7:0] cs;
    // Frame-level expectation.
    n        = {f[0], f[1]};
    too_big  = n > (1 << AW);
    consumed = too_big ? 2 : f.size();
    ok       = 1'b0;
    if (!too_big) begin
      cs = 8'h00;
      for (int i = 0; i < 2 + 2 * n; i++) cs ^= f[i];
      ok = (cs == f[2 + 2 * n]);
    end
    cap.delete();
    pulse_start();
    check("busy_at_start", 32'(busy), 32'd1);
    check("flags_at_start", {30'd0, done, error}, 32'd0);
    check("cpurst_at_start", 32'(cpu_rst), 32'd1);
    for (int i = 0; i < consumed; i++) send_byte(f[i], gmax, poke && i == 3);
    w = 0;
    while (busy && w < 64) begin
      @(negedge clk);
      w++;
    end
    check("end_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'(ok));
    check("end_error", 32'(error), 32'(!ok));
    check("end_cpurst", 32'(cpu_rst), 32'(!ok));
    w = too_big ? 0 : n;
    check("n_writes", 32'(cap.size()), 32'(w));
    for (int i = 0; i < w && i < cap.size(); i++) begin
      check("wr_addr", 32'(cap[i][AW+DW-1:DW]), 32'(i));
      check("wr_data", 32'(cap[i][DW-1:0]), {16'd0, f[2 + 2 * i], f[3 + 2 * i]});
    end
  endtask

  task automatic reset_midcycle();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_cpurst", 32'(cpu_rst), 32'd1);
    check("rst_rdy", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(rom_we), 32'd0);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_wdata", 32'(rom_wdata), 32'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    bq_t f;
    int k;
    int nc;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    check("por_cpurst", 32'(cpu_rst), 32'd1);
    check("por_rdy", 32'(rx_ready), 32'd0);
    check("por_flags", {29'd0, busy, done, error}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Datasheet frame.
    f = '{8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h07, 8'hF9};
    run_frame(f, 0, 1'b0);
    // Stream traffic after DONE is not consumed.
    nc = cap.size();
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (4) begin
      @(negedge clk);
      check("done_rdy", 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;
    check("done_hold", 32'(done), 32'd1);
    check("done_nowr", 32'(cap.size()), 32'(nc));

    // Bad checksum, then recovery with a good frame.
    f = '{8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h07, 8'h00};
    run_frame(f, 0, 1'b0);
    f = '{8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h07, 8'hF9};
    run_frame(f, 3, 1'b0);

    // Empty image.
    f = '{8'h00, 8'h00, 8'h00};
    run_frame(f, 0, 1'b0);

    // Random frames with stream gaps and stray start pulses while busy.
    for (int it = 0; it < 20; it++) begin
      f = make_frame($urandom_range(0, 6), $urandom_range(0, 3) == 0);
      run_frame(f, 10, ($urandom_range(0, 1) == 1) && f.size() > 3);
    end

    // Length beyond the ROM: error straight after LEN_LO, nothing consumed.
    f = '{8'h80, 8'h01};
    run_frame(f, 0, 1'b0);
    rx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("badlen_rdy", 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;
    check("badlen_err", 32'(error), 32'd1);

    // Largest legal length is accepted.
    pulse_start();
    send_byte(8'h80, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    check("maxlen_err", 32'(error), 32'd0);
    check("maxlen_rdy", 32'(rx_ready), 32'd1);
    check("maxlen_busy", 32'(busy), 32'd1);
    reset_midcycle();

    // Stream stops after LEN_LO: ERROR exactly TMO cycles later.
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    k = 0;
    while (!error && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cycles", 32'(k), 32'(TMO));
    check("tmo_cpurst", 32'(cpu_rst), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);

    // Reset after word 1 of 4: no further writes, CPU held in reset.
    cap.delete();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'hCD, 0, 1'b0);
    @(negedge clk);
    check("mid_wr1", 32'(cap.size()), 32'd1);
    reset_midcycle();
    cap.delete();
    repeat (30) begin
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("mid_nowr", 32'(cap.size()), 32'd0);
    check("mid_cpurst", 32'(cpu_rst), 32'd1);
    check("mid_idle", {29'd0, busy, done, error}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
